gpio_in_debounce: RTL
=====================

# gpio_in_debounce

Input conditioning stage placed directly upstream of the CoreGPIO input port in the MiV creative-board fabric. Each raw board input (push-button or DIP switch) passes through a two-flop synchroniser and then a per-channel counter-qualified debouncer. The clean level drives CoreGPIO `GPIO_IN`, so its edge-type interrupts fire once per physical press. Single-cycle rise/fall strobes are also provided for fabric logic that bypasses the processor.

## Interface

Parameters:
- `IO_NUM`, 4: number of channels; matches the CoreGPIO `IO_NUM`.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable PCLK samples required before the output changes; legal range 1..2^`CNT_WIDTH`-1.
- `CNT_WIDTH`, 16: width of each channel's qualification counter.
- `RESET_VAL`, 0: `IO_NUM`-bit reset level of the synchronisers and `GPIO_IN`.

Ports:
- `PCLK`, in, 1: the single clock; all logic is on the rising edge.
- `PRESETN`, in, 1: asynchronous, active-low reset.
- `BTN_RAW`, in, `IO_NUM`: asynchronous raw pad inputs.
- `GPIO_IN`, out, `IO_NUM`: registered debounced level; connects to CoreGPIO `GPIO_IN`.
- `RISE`, out, `IO_NUM`: one-cycle pulse when the matching `GPIO_IN` bit goes 0->1.
- `FALL`, out, `IO_NUM`: one-cycle pulse when the matching `GPIO_IN` bit goes 1->0.
- `BUSY`, out, `IO_NUM`: channel is in the QUALIFY state.

## Operation

- **Channel independence:** each channel is fully independent; there is no shared counter and no arbitration.
- **Synchroniser:** `sync1` <= `BTN_RAW`, then `sync2` <= `sync1`. Only `sync2` is used downstream.
- **Mismatch:** `mis` = (`sync2` != `GPIO_IN`).
- **Per-channel state machine:**
  - STABLE, `mis`=0: remain in STABLE; `cnt`=0.
  - STABLE, `mis`=1, `DEBOUNCE_CYCLES`=1: toggle `GPIO_IN` immediately and stay in STABLE.
  - STABLE, `mis`=1, otherwise: go to QUALIFY with `cnt`=1.
  - QUALIFY, `mis`=0: go to STABLE with `cnt`=0 (glitch rejected; no output change, no strobe).
  - QUALIFY, `mis`=1, `cnt`=`DEBOUNCE_CYCLES`-1: toggle `GPIO_IN`, go to STABLE, `cnt`=0.
  - QUALIFY, `mis`=1, otherwise: `cnt`+1.
- **Counter width:** `cnt` never exceeds `DEBOUNCE_CYCLES`-1, so no wrap-around is possible. No saturation logic is required.
- **Strobes:** `RISE`/`FALL` are registered in the same edge that updates `GPIO_IN`: `RISE` = new 1 & old 0, `FALL` = new 0 & old 1. They clear on the next edge.
- **Busy:** `BUSY` = (state == QUALIFY), registered.
- **Simultaneous events:** different channels may update and pulse in the same cycle; e.g. a `RISE` on one bit and a `FALL` on another are legal together.
- **Reset, mid-operation or otherwise:**
  - `sync1`, `sync2` and `GPIO_IN` take `RESET_VAL`.
  - `RISE`, `FALL` and `BUSY` clear to 0; all counters clear to 0; all channels go to STABLE.
  - Any qualification in progress is discarded without a pulse.
- **Reset values of every output:** `GPIO_IN`=`RESET_VAL`, `RISE`=0, `FALL`=0, `BUSY`=0.

## Timing

- **Raw-change latency:** `BTN_RAW` stable across edges 1..N:
  - `sync2` holds the new value after edge 2.
  - Mismatch is sampled at edges 3..`DEBOUNCE_CYCLES`+2.
  - `GPIO_IN` and the strobe update at edge `DEBOUNCE_CYCLES`+2.
- **Strobe width:** `RISE`/`FALL` are high for exactly one PCLK cycle.
- **Busy duration:** on a qualified change, `BUSY` is high for `DEBOUNCE_CYCLES`-1 cycles (edges 3 to `DEBOUNCE_CYCLES`+2). It is never high when `DEBOUNCE_CYCLES`=1.
- **Rejected pulses:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles (as seen at `sync2`) never reaches `GPIO_IN`.
- **Glitch-free outputs:** all outputs come straight from flops, with no combinational path from `BTN_RAW`.
- **Reset assertion:** asynchronous; outputs take their reset values without waiting for an edge.
- **Reset release:** synchronous to PCLK (a reset synchroniser is provided at system level).

## Test plan

Bench uses `IO_NUM`=4, `DEBOUNCE_CYCLES`=4, `CNT_WIDTH`=3, `RESET_VAL`=0.

- **Reset with inputs high:** `PRESETN`=0 with `BTN_RAW`=4'hF -> `GPIO_IN`=0, `RISE`=`FALL`=`BUSY`=0. After release, `GPIO_IN`=4'hF at the 6th edge, with `RISE`=4'hF for one cycle.
- **Clean press:** `BTN_RAW[0]` 0->1 held -> `BUSY[0]` high for 3 cycles, then `GPIO_IN[0]`=1 and `RISE[0]`=1 together, 6 edges after the change. `RISE[0]` is 0 one cycle later.
- **Glitch reject:** `BTN_RAW[1]` high for 3 cycles, then low -> `GPIO_IN[1]` stays 0, no `RISE`/`FALL`, `BUSY[1]` returns to 0.
- **Bounce train:** `BTN_RAW[2]` toggles every 2 cycles for 20 cycles, then stays 1 -> exactly one `RISE[2]`, 6 edges after the final transition; `FALL[2]` never asserts.
- **Simultaneous:** with `GPIO_IN`=4'b1000, drive `BTN_RAW`=4'b0100 in one cycle -> `RISE[2]` and `FALL[3]` pulse in the same cycle, and `GPIO_IN`=4'b0100.
- **Reset mid-qualify:** assert `PRESETN`=0 after 2 mismatch edges on bit 0 -> `GPIO_IN`, `BUSY` and strobes are 0 immediately (no pulse). After release with `BTN_RAW[0]` still 1, a full 6-edge qualification is required.

Source files
------------

// File: rtl/gpio_in_debounce.sv
// Board input conditioning ahead of CoreGPIO: two-flop synchroniser followed by
// an independent counter-qualified debouncer per channel, with rise/fall strobes.
module gpio_in_debounce #(
    parameter int unsigned       IO_NUM          = 4,
    parameter int unsigned       DEBOUNCE_CYCLES = 50000,
    parameter int unsigned       CNT_WIDTH       = 16,
    parameter logic [IO_NUM-1:0] RESET_VAL       = '0
) (
    input  logic              PCLK,
    input  logic              PRESETN,
    input  logic [IO_NUM-1:0] BTN_RAW,
    output logic [IO_NUM-1:0] GPIO_IN,
    output logic [IO_NUM-1:0] RISE,
    output logic [IO_NUM-1:0] FALL,
    output logic [IO_NUM-1:0] BUSY
);

    typedef enum logic {
        STABLE  = 1'b0,
        QUALIFY = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam bit                   IMMEDIATE = (DEBOUNCE_CYCLES == 1);

    logic [IO_NUM-1:0]    sync1;
    logic [IO_NUM-1:0]    sync2;
    logic [IO_NUM-1:0]    mis;
    state_t               state [IO_NUM];
    logic [CNT_WIDTH-1:0] cnt   [IO_NUM];

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
        end else begin
            sync1 <= BTN_RAW;
            sync2 <= sync1;
        end
    end

    always_comb begin
        mis = sync2 ^ GPIO_IN;
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            GPIO_IN <= RESET_VAL;
            RISE    <= '0;
            FALL    <= '0;
            BUSY    <= '0;
            for (int unsigned i = 0; i < IO_NUM; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            // Strobes default low; a toggling channel overrides its own bit below.
            RISE <= '0;
            FALL <= '0;
            for (int unsigned i = 0; i < IO_NUM; i++) begin
                case (state[i])
                    STABLE: begin
                        cnt[i] <= '0;
                        if (mis[i]) begin
                            if (IMMEDIATE) begin
                                GPIO_IN[i] <= ~GPIO_IN[i];
                                RISE[i]    <= ~GPIO_IN[i];
                                FALL[i]    <= GPIO_IN[i];
                            end else begin
                                state[i] <= QUALIFY;
                                BUSY[i]  <= 1'b1;
                                cnt[i]   <= CNT_ONE;
                            end
                        end
                    end
                    QUALIFY: begin
                        if (!mis[i]) begin
                            state[i] <= STABLE;
                            BUSY[i]  <= 1'b0;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_LAST) begin
                            GPIO_IN[i] <= ~GPIO_IN[i];
                            RISE[i]    <= ~GPIO_IN[i];
                            FALL[i]    <= GPIO_IN[i];
                            state[i]   <= STABLE;
                            BUSY[i]    <= 1'b0;
                            cnt[i]     <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_ONE;
                        end
                    end
                    default: begin
                        state[i] <= STABLE;
                        BUSY[i]  <= 1'b0;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule
